// File: rtl/call_return_predictor_if.sv
// RAS command/response bundle between the fetch next-PC stage (master) and the RAS (slave).
interface call_return_predictor_if #(
  parameter int unsigned XLEN = 32
) ();
  logic [XLEN-1:0] ras_address_in;
  logic            ras_valid_in;
  logic            ras_op;
  logic            ras_checkpoint;
  logic            ras_restore_checkpoint;
  logic [XLEN-1:0] ras_address_out;
  logic            ras_valid_out;

  modport master (
    output ras_address_in,
    output ras_valid_in,
    output ras_op,
    output ras_checkpoint,
    output ras_restore_checkpoint,
    input  ras_address_out,
    input  ras_valid_out
  );

  modport slave (
    input  ras_address_in,
    input  ras_valid_in,
    input  ras_op,
    input  ras_checkpoint,
    input  ras_restore_checkpoint,
    output ras_address_out,
    output ras_valid_out
  );
endinterface

// File: rtl/call_return_predictor.sv
// call_return_predictor: owns the fetch PC, predecodes JAL/JALR/BRANCH and drives
// RAS push/pop/checkpoint/restore, consuming the registered pop result one cycle later.
// RAS commands are combinational from the fetched instruction so a return costs two cycles.
// Build option: define RAS_POP_PUSH_EN to handle JALR with distinct link rd/rs1 as pop-then-push;
// otherwise that case is a plain push and no pending-push state is built.
module call_return_predictor #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             instr_in,
  input  logic                    instr_valid,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic [XLEN-1:0]         pc_out,
  output logic                    pc_valid,
  output logic                    pred_taken,
  call_return_predictor_if.master ras
);
  localparam int unsigned OPW  = 7;
  localparam int unsigned REGW = 5;
  localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    POP_WAIT = 2'd1,
    STALL    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic [OPW-1:0]  opcode;
  logic [REGW-1:0] rd, rs1;
  logic            rd_link, rs1_link;
  logic [XLEN-1:0] j_imm, b_imm, pc_plus4;

`ifdef RAS_POP_PUSH_EN
  logic            push_pend_q, push_pend_d;
  logic [XLEN-1:0] link_q, link_d;
`endif

  // Field extraction, link-register hints and sign-extended immediates.
  assign opcode   = instr_in[6:0];
  assign rd       = instr_in[11:7];
  assign rs1      = instr_in[19:15];
  assign rd_link  = (rd == REGW'(1)) || (rd == REGW'(5));
  assign rs1_link = (rs1 == REGW'(1)) || (rs1 == REGW'(5));
  assign j_imm    = XLEN'($signed({instr_in[31], instr_in[19:12], instr_in[20],
                                   instr_in[30:21], 1'b0}));
  assign b_imm    = XLEN'($signed({instr_in[31], instr_in[7], instr_in[30:25],
                                   instr_in[11:8], 1'b0}));
  assign pc_plus4 = pc_q + XLEN'(4);
  assign pc_out   = pc_q;

  // State, PC and pending-push registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
`ifdef RAS_POP_PUSH_EN
      push_pend_q <= 1'b0;
      link_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
`ifdef RAS_POP_PUSH_EN
      push_pend_q <= push_pend_d;
      link_q      <= link_d;
`endif
    end
  end

  // Next-state, next-PC and RAS command decode; everything stays zero while in reset.
  always_comb begin
    state_d                    = state_q;
    pc_d                       = pc_q;
    pc_valid                   = 1'b0;
    pred_taken                 = 1'b0;
    ras.ras_address_in         = '0;
    ras.ras_valid_in           = 1'b0;
    ras.ras_op                 = 1'b0;
    ras.ras_checkpoint         = 1'b0;
    ras.ras_restore_checkpoint = 1'b0;
`ifdef RAS_POP_PUSH_EN
    push_pend_d                = push_pend_q;
    link_d                     = link_q;
`endif
    if (reset) begin
      if (redirect_valid) begin
        pc_d                       = redirect_pc;
        state_d                    = RUN;
        ras.ras_restore_checkpoint = 1'b1;
`ifdef RAS_POP_PUSH_EN
        push_pend_d                = 1'b0;
`endif
      end else begin
        case (state_q)
          RUN: begin
            pc_valid = 1'b1;
            if (instr_valid) begin
              pc_d = pc_plus4;
              case (opcode)
                OP_JAL: begin
                  pc_d       = pc_q + j_imm;
                  pred_taken = 1'b1;
                  if (rd_link) begin
                    ras.ras_valid_in   = 1'b1;
                    ras.ras_address_in = pc_plus4;
                  end
                end
                OP_BRANCH: begin
                  ras.ras_checkpoint = 1'b1;
                  if (instr_in[31]) begin
                    pc_d       = pc_q + b_imm;
                    pred_taken = 1'b1;
                  end
                end
                OP_JALR: begin
                  if (rs1_link && !rd_link) begin
                    ras.ras_valid_in = 1'b1;
                    ras.ras_op       = 1'b1;
                    pc_d             = pc_q;
                    state_d          = POP_WAIT;
                  end
`ifdef RAS_POP_PUSH_EN
                  else if (rs1_link && rd_link && (rd != rs1)) begin
                    ras.ras_valid_in = 1'b1;
                    ras.ras_op       = 1'b1;
                    pc_d             = pc_q;
                    state_d          = POP_WAIT;
                    push_pend_d      = 1'b1;
                    link_d           = pc_plus4;
                  end
`endif
                  else if (rd_link) begin
                    ras.ras_valid_in   = 1'b1;
                    ras.ras_address_in = pc_plus4;
                  end
                end
                default: ;
              endcase
            end
          end
          POP_WAIT: begin
            if (ras.ras_valid_out) begin
              pc_d       = ras.ras_address_out;
              pred_taken = 1'b1;
              state_d    = RUN;
`ifdef RAS_POP_PUSH_EN
              if (push_pend_q) begin
                ras.ras_valid_in   = 1'b1;
                ras.ras_address_in = link_q;
              end
`endif
            end else begin
              state_d = STALL;
            end
`ifdef RAS_POP_PUSH_EN
            push_pend_d = 1'b0;
`endif
          end
          STALL: ;
          default: state_d = RUN;
        endcase
      end
    end
  end
endmodule

// File: doc/call_return_predictor.md
Name: call_return_predictor

Overview:
- Fetch-side next-PC stage that sits directly upstream of the return address stack (RAS).
- Owns the fetch PC register and predecodes each fetched instruction.
- Classifies JAL/JALR against the RISC-V link-register hint rules (x1/x5) and drives RAS push/pop/checkpoint/restore.
- Consumes the registered RAS pop result to form the predicted return target.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- instr_in  in  32  instruction at pc_out (combinational from I-mem).
- instr_valid  in  1  instr_in valid this cycle.
- redirect_valid  in  1  branch resolution mispredict; overrides everything except reset.
- redirect_pc  in  XLEN  corrected PC.
- pc_out  out  XLEN  current fetch PC.
- pc_valid  out  1  pc_out is a real fetch request.
- pred_taken  out  1  fetched instr predicted to redirect (JAL, taken branch, popped return).
- ras_address_in  out  XLEN  push value (link address = instr PC + 4).
- ras_valid_in  out  1  RAS op this cycle.
- ras_op  out  1  0 = push, 1 = pop.
- ras_checkpoint  out  1  snapshot RAS pointer.
- ras_restore_checkpoint  out  1  restore RAS pointer.
- ras_address_out  in  XLEN  popped address, valid the cycle after the pop.
- ras_valid_out  in  1  popped entry was valid.

Behaviour:
- Reset (reset==0 at posedge): pc_out=RESET_PC, state=RUN, all outputs 0 except pc_out, pc_valid=0 for that cycle. Reset mid-POP_WAIT discards the pending pop/push.
- States: RUN, POP_WAIT, STALL.
- RUN, instr_valid=1, decode on opcode:
  - JAL: next PC = pc+J-imm; pred_taken=1; if rd∈{x1,x5} then push pc+4.
  - BRANCH: backward (imm sign bit 1) predicted taken, pc+B-imm; forward: pc+4. ras_checkpoint=1 in the same cycle, with no push/pop.
  - JALR hint table, with link = x1 or x5:
    - rd!link, rs1!link: no op; next PC = pc+4.
    - rd!link, rs1 link: pop; go to POP_WAIT.
    - rd link, rs1!link: push pc+4; next PC = pc+4.
    - rd link, rs1 link, rd==rs1: push pc+4; next PC = pc+4.
    - rd link, rs1 link, rd!=rs1: pop-then-push (see Optional Feature).
  - Other opcodes: next PC = pc+4.
- RUN, instr_valid=0: hold pc_out.
- At most one of {push, pop, checkpoint} per cycle; ras_valid_in and ras_checkpoint are never both 1 (except for restore, below).
- POP_WAIT:
  - pc_valid=0; latch nothing new.
  - If ras_valid_out=1: pc <= ras_address_out, pred_taken=1, return to RUN. If a push is pending, issue push of saved JALR pc+4 this cycle.
  - If ras_valid_out=0 (empty stack): go to STALL and do not issue the pending push.
- STALL: pc_valid=0; leave only on redirect.
- Redirect (any state): pc <= redirect_pc; state=RUN; ras_restore_checkpoint=1; ras_valid_in=0; ras_checkpoint=0; pending push dropped. pc_valid=0 that cycle, fetch resumes next cycle.
- PC arithmetic is modulo 2^XLEN; wrap at all-ones is silent. Immediates are sign-extended to XLEN.
- Latency: sequential next PC is 1 cycle per instruction; a return costs 2 cycles (pop, then consume).

Optional Feature:
- Macro RAS_POP_PUSH_EN.
- Defined: the rd/rs1-both-link, rd!=rs1 case pops, enters POP_WAIT with push pending, then pushes pc+4 while redirecting to the popped address.
- Undefined: that case is treated as push-only (push pc+4; next PC = pc+4), and no pending-push logic is built.

Test Plan:
- Reset: hold reset=0 for 2 cycles with RESET_PC=0x100 → pc_out=0x100, all RAS outputs 0; first fetch after release is at 0x100.
- Call: JAL x1,+0x40 at 0x100 → push 0x104 (ras_op=0, ras_valid_in=1); next pc_out=0x140, pred_taken=1.
- Return: JALR x0,0(x1) at 0x200; RAS returns 0x104/valid → pop cycle, then pc_out=0x104 two cycles after the JALR fetch.
- Empty-stack return: pop returns ras_valid_out=0 → STALL with pc_valid=0; redirect_pc=0x300 → pc_out=0x300, ras_restore_checkpoint pulses 1 cycle.
- Branch checkpoint and redirect: BEQ imm=-8 at 0x180 → ras_checkpoint=1, next pc 0x178; redirect to 0x184 in the same cycle as a JAL push → redirect wins, no push, restore=1.
- Coroutine swap: JALR x5,0(x1) at 0x400 with macro defined → pop, then push 0x404 with pc=popped value. Without the macro → single push 0x404, next pc 0x404.
